// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared bus widths, initiator state type and address helper
package common_pkg;

    localparam int WB_ADDR_WIDTH          = 17;
    localparam int DATA_WIDTH             = 8;
    localparam int WB_INIT_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        RESP     = 2'd3
    } wb_init_state_t;

    // The ram responder is mapped from address zero.
    function automatic logic [WB_ADDR_WIDTH-1:0] wb_ram_addr(input logic [WB_ADDR_WIDTH-1:0] offset);
        return offset;
    endfunction

endpackage

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - single-beat Wishbone B4 pipelined initiator with timeout
module wb_initiator #(
    parameter int ADDR_WIDTH     = common_pkg::WB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = common_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = common_pkg::WB_INIT_TIMEOUT_CYCLES
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  wb_we_o,
    output logic                  wb_cycle_o,
    output logic                  wb_strobe_o,
    input  logic                  wb_stall_i,
    input  logic                  wb_ack_i
);
    import common_pkg::*;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Compared against the pre-increment count, so the abort edge is the one
    // on which the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    wb_init_state_t        state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  tmo_expire;

    assign tmo_expire = (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        tmo_d       = tmo_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d    = cmd_we_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_data_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                tmo_d = tmo_q + TW'(1);
                if (!wb_stall_i && wb_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = we_q ? '0 : wb_data_i;
                    state_d     = RESP;
                end else if (tmo_expire) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = RESP;
                end else if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                tmo_d = tmo_q + TW'(1);
                if (wb_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = we_q ? '0 : wb_data_i;
                    state_d     = RESP;
                end else if (tmo_expire) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Registered ready follows the next state so a consumed response
        // reopens the command port on the very next clock.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign wb_we_o     = we_q;
    assign wb_cycle_o  = cyc_q;
    assign wb_strobe_o = stb_q;

endmodule
